// File: rtl/mod_unit.sv
`timescale 1ns/1ps
// mod_unit: iterative unsigned remainder engine (r = a mod b).
// Restoring shift-subtract, one dividend bit per clock. Serves as the
// remainder datapath of a Euclidean GCD controller: the controller holds
// run high, takes r on the single cycle ready is high, and reloads operands.
module mod_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  // a_q is shifted left every iteration so its MSB is always the next dividend bit.
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] r_n;
  logic             ready_n;

  // One restoring step. The trial value is one bit wider than the operands so
  // the compare/subtract cannot overflow anywhere in the unsigned range. With
  // b=0 the subtract is a no-op, so the remainder just accumulates a.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_rem;

  // Datapath for a single iteration.
  always_comb begin
    trial    = {rem, a_q[WIDTH-1]};
    diff     = trial - {1'b0, b_q};
    step_rem = (trial >= {1'b0, b_q}) ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  // Next-state and next-output logic for the IDLE/BUSY/DONE controller.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    rem_n   = rem;
    count_n = count;
    r_n     = r;
    ready_n = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          a_n     = a;
          b_n     = b;
          rem_n   = '0;
          count_n = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (!run) begin
          // Abort: drop the partial result, leave r untouched.
          state_n = IDLE;
        end else begin
          a_n     = a_q << 1;
          rem_n   = step_rem;
          count_n = count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            r_n     = step_rem;
            ready_n = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        // ready is high for exactly this one cycle, whatever run does.
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all datapath registers are reset too (there is no memory array
    // here), so an in-flight result can never surface after a reset.
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      rem   <= '0;
      count <= '0;
      r     <= '0;
      ready <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, independent of statement order.
      state <= state_n;
      a_q   <= a_n;
      b_q   <= b_n;
      rem   <= rem_n;
      count <= count_n;
      r     <= r_n;
      ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_mod_unit.sv
`timescale 1ns/1ps
// Directed and randomized bench for mod_unit.
module tb_mod_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] r;
  logic        ready;

  int checks    = 0;
  int errors    = 0;
  int ready_cnt = 0;

  always #5 clk = ~clk;

  mod_unit dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .a     (a),
    .b     (b),
    .r     (r),
    .ready (ready)
  );

  // Count every ready pulse for the one-pulse-per-latch scoreboard.
  always @(negedge clk) if (ready === 1'b1) ready_cnt++;

  // Start one operation from IDLE (called #1 after a rising edge) and wait
  // for ready. lat = edges after the latch edge; 100 means timeout.
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob,
                       output logic [31:0] res, output int lat);
    a   = oa;
    b   = ob;
    run = 1'b1;
    @(posedge clk);
    lat = 0;
    res = 'x;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready === 1'b1) begin
        res = r;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    run = 1'b0;
    a   = '0;
    b   = '0;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL reset_r got %0d want 0", r); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] res;
    int lat;
    do_op(32'd100, 32'd7, res, lat);
    checks++;
    if (lat !== 32) begin errors++; $display("FAIL basic_latency got %0d want 32", lat); end
    checks++;
    if (res !== 32'd2) begin errors++; $display("FAIL basic_r got %0d want 2", res); end
    run = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low got %b want 0", ready); end
  endtask

  task automatic test_directed;
    logic [31:0] va [6] = '{32'd35, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd12, 32'd0};
    logic [31:0] vb [6] = '{32'd7,  32'd9, 32'd1,         32'h0001_0000, 32'd0, 32'd0};
    logic [31:0] ve [6] = '{32'd0,  32'd5, 32'd0,         32'h0000_FFFF, 32'd12, 32'd0};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], res, lat);
      checks++;
      if (res !== ve[i]) begin
        errors++;
        $display("FAIL directed_r[%0d] a=%h b=%h got %h want %h", i, va[i], vb[i], res, ve[i]);
      end
      checks++;
      if (lat !== 32) begin errors++; $display("FAIL directed_latency[%0d] got %0d want 32", i, lat); end
      run = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL directed_ready_low[%0d] got %b want 0", i, ready); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_r [3] = '{32'd12, 32'd6, 32'd0};
    int cyc  = 0;
    int last = 0;
    int n    = 0;
    a   = 32'd48;
    b   = 32'd18;
    run = 1'b1;
    for (int k = 0; k < 200 && n < 3; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready === 1'b1) begin
        checks++;
        if (r !== exp_r[n]) begin errors++; $display("FAIL b2b_r[%0d] got %0d want %0d", n, r, exp_r[n]); end
        if (n > 0) begin
          checks++;
          if (cyc - last != 34) begin errors++; $display("FAIL b2b_period[%0d] got %0d want 34", n, cyc - last); end
        end
        last = cyc;
        a    = b;
        b    = r;
        n++;
        if (n == 3) run = 1'b0;
      end
    end
    run = 1'b0;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL b2b_results got %0d want 3", n); end
    checks++;
    if (a !== 32'd6) begin errors++; $display("FAIL b2b_gcd got %0d want 6", a); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort;
    logic [31:0] res;
    int lat;
    int cnt0;
    a   = 32'd1000;
    b   = 32'd3;
    run = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    run  = 1'b0;
    cnt0 = ready_cnt;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (ready_cnt !== cnt0) begin errors++; $display("FAIL abort_no_ready got %0d pulses want 0", ready_cnt - cnt0); end
    checks++;
    if (dut.state !== 2'd0) begin errors++; $display("FAIL abort_idle got state %0d want 0", dut.state); end
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL abort_r_held got %0d want 0", r); end
    do_op(32'd1000, 32'd3, res, lat);
    checks++;
    if (res !== 32'd1) begin errors++; $display("FAIL abort_rerun_r got %0d want 1", res); end
    checks++;
    if (lat !== 32) begin errors++; $display("FAIL abort_rerun_latency got %0d want 32", lat); end
    run = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int lat;
    int cnt0;
    a   = 32'd1000;
    b   = 32'd7;
    run = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", ready); end
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL midrst_r got %0d want 0", r); end
    cnt0 = ready_cnt;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_held got %b want 0", ready); end
    rst = 1'b0;
    do_op(32'd1000, 32'd7, res, lat);
    checks++;
    if (res !== 32'd6) begin errors++; $display("FAIL midrst_restart_r got %0d want 6", res); end
    checks++;
    if (lat !== 32) begin errors++; $display("FAIL midrst_restart_latency got %0d want 32", lat); end
    run = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready_cnt - cnt0 !== 1) begin errors++; $display("FAIL midrst_pulses got %0d want 1", ready_cnt - cnt0); end
  endtask

  task automatic gen_pair(input int i, output logic [31:0] oa, output logic [31:0] ob);
    case (i % 5)
      0: begin oa = $urandom; ob = 32'd0; end
      1: begin ob = $urandom | 32'h8000_0000; oa = $urandom % ob; end
      2: begin oa = $urandom; ob = oa; end
      3: begin oa = $urandom; ob = $urandom_range(1, 1000); end
      default: begin oa = $urandom; ob = $urandom >> ($urandom % 32); end
    endcase
  endtask

  task automatic test_random;
    localparam int N_OPS = 500;
    logic [31:0] oa, ob, exp_r;
    int cnt0;
    bit found;
    cnt0 = ready_cnt;
    gen_pair(0, oa, ob);
    a   = oa;
    b   = ob;
    run = 1'b1;
    for (int i = 0; i < N_OPS; i++) begin
      exp_r = (ob == 32'd0) ? oa : oa % ob;
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (ready === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL rand_timeout[%0d] a=%h b=%h", i, oa, ob); end
      checks++;
      if (r !== exp_r) begin errors++; $display("FAIL rand_r[%0d] a=%h b=%h got %h want %h", i, oa, ob, r, exp_r); end
      if (i < N_OPS - 1) begin
        gen_pair(i + 1, oa, ob);
        a = oa;
        b = ob;
      end else begin
        run = 1'b0;
      end
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (ready_cnt - cnt0 !== N_OPS) begin
      errors++;
      $display("FAIL rand_pulse_count got %0d want %0d", ready_cnt - cnt0, N_OPS);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
